// File: rtl/svm_pwm_capture.sv
// rtl/svm_pwm_capture.sv - per-window PWM high-time and period capture for svm
module svm_pwm_capture #(
  parameter int D_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pwmA,
  input  logic               pwmB,
  input  logic               pwmC,
  input  logic               halt,
  input  logic [D_WIDTH-1:0] periodTop,
  output logic [D_WIDTH-1:0] dutyA,
  output logic [D_WIDTH-1:0] dutyB,
  output logic [D_WIDTH-1:0] dutyC,
  output logic [D_WIDTH-1:0] perLen,
  output logic               valid,
  output logic               errPeriod,
  output logic [2:0]         errMulti,
  output logic               ovf
);

  typedef enum logic {IDLE, MEASURE} state_t;
  localparam logic [D_WIDTH-1:0] CNT_MAX = '1;

  state_t             state_q, state_d;
  logic [D_WIDTH-1:0] duty_q   [3];
  logic [D_WIDTH-1:0] duty_nxt [3];
  logic [1:0]         edge_q   [3];
  logic [1:0]         edge_nxt [3];
  logic [D_WIDTH-1:0] per_q, per_nxt, exp_top;
  logic [2:0]         pwm, pwm_prev, rise, duty_sat;
  logic               per_sat, ovf_q, ovf_nxt;
  logic               open_win, close_win;

  assign pwm  = {pwmC, pwmB, pwmA};
  assign rise = pwm & ~pwm_prev;

  // Next counts always include the current sample, so a closing halt cycle is counted.
  always_comb begin
    state_d   = state_q;
    open_win  = 1'b0;
    close_win = 1'b0;
    per_sat   = (per_q == CNT_MAX);
    per_nxt   = per_sat ? per_q : per_q + 1'b1;
    duty_sat  = '0;
    for (int i = 0; i < 3; i++) begin
      duty_sat[i] = pwm[i] && (duty_q[i] == CNT_MAX);
      duty_nxt[i] = duty_q[i] + {{(D_WIDTH-1){1'b0}}, (pwm[i] && !duty_sat[i])};
      edge_nxt[i] = (rise[i] && edge_q[i] != 2'd3) ? edge_q[i] + 2'd1 : edge_q[i];
    end
    ovf_nxt = ovf_q | per_sat | (|duty_sat);
    case (state_q)
      IDLE: begin
        if (halt) begin
          state_d  = MEASURE;
          open_win = 1'b1;
        end
      end
      MEASURE: close_win = halt;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      per_q     <= '0;
      exp_top   <= '0;
      ovf_q     <= 1'b0;
      pwm_prev  <= '0;
      for (int i = 0; i < 3; i++) begin
        duty_q[i] <= '0;
        edge_q[i] <= '0;
      end
      dutyA     <= '0;
      dutyB     <= '0;
      dutyC     <= '0;
      perLen    <= '0;
      valid     <= 1'b0;
      errPeriod <= 1'b0;
      errMulti  <= '0;
      ovf       <= 1'b0;
    end else begin
      state_q  <= state_d;
      pwm_prev <= pwm;
      valid    <= close_win;
      if (open_win || close_win) begin
        per_q   <= '0;
        ovf_q   <= 1'b0;
        exp_top <= periodTop;
        for (int i = 0; i < 3; i++) begin
          duty_q[i] <= '0;
          edge_q[i] <= '0;
        end
      end else if (state_q == MEASURE) begin
        per_q <= per_nxt;
        ovf_q <= ovf_nxt;
        for (int i = 0; i < 3; i++) begin
          duty_q[i] <= duty_nxt[i];
          edge_q[i] <= edge_nxt[i];
        end
      end
      if (close_win) begin
        dutyA     <= duty_nxt[0];
        dutyB     <= duty_nxt[1];
        dutyC     <= duty_nxt[2];
        perLen    <= per_nxt;
        errPeriod <= (per_nxt != exp_top);
        errMulti  <= {edge_nxt[2][1], edge_nxt[1][1], edge_nxt[0][1]};
        ovf       <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_svm_pwm_capture.sv
// tb/tb_svm_pwm_capture.sv - randomized bench for svm_pwm_capture against a window model
module tb_svm_pwm_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b0, pwmA = 1'b0, pwmB = 1'b0, pwmC = 1'b0, halt = 1'b0;
  logic [15:0] periodTop = 16'd0;
  logic [15:0] dutyA, dutyB, dutyC, perLen;
  logic        valid, errPeriod, ovf;
  logic [2:0]  errMulti;
  logic [69:0] got;

  int total = 0;
  int bad   = 0;

  // Window model: unbounded integer tallies, clipped only when a window is published.
  bit          aligned = 1'b0;
  bit   [2:0]  m_prev  = 3'b0;
  int          m_per   = 0;
  int          m_duty  [3];
  int          m_edges [3];
  logic [15:0] m_top   = 16'd0;
  logic [15:0] e_duty  [3];
  logic [15:0] e_per   = 16'd0;
  logic        e_errp  = 1'b0, e_ovf = 1'b0, e_valid = 1'b0;
  logic [2:0]  e_multi = 3'b0;

  svm_pwm_capture #(.D_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .pwmA(pwmA), .pwmB(pwmB), .pwmC(pwmC), .halt(halt),
    .periodTop(periodTop), .dutyA(dutyA), .dutyB(dutyB), .dutyC(dutyC),
    .perLen(perLen), .valid(valid), .errPeriod(errPeriod), .errMulti(errMulti), .ovf(ovf)
  );

  always #5 clk = ~clk;

  assign got = {dutyA, dutyB, dutyC, perLen, errPeriod, errMulti, ovf, valid};

  function automatic logic [15:0] sat16(input int x);
    return (x > 65535) ? 16'hFFFF : x[15:0];
  endfunction

  function automatic logic [69:0] exp_vec();
    return {e_duty[0], e_duty[1], e_duty[2], e_per, e_errp, e_multi, e_ovf, e_valid};
  endfunction

  task automatic clear_tallies();
    m_per = 0;
    for (int i = 0; i < 3; i++) begin
      m_duty[i]  = 0;
      m_edges[i] = 0;
    end
  endtask

  task automatic step(input bit a, input bit b, input bit c, input bit h, input bit r);
    bit [2:0] s;
    s = {c, b, a};
    pwmA = a; pwmB = b; pwmC = c; halt = h; rst = r;
    @(posedge clk);
    #1;
    e_valid = 1'b0;
    if (r) begin
      aligned = 1'b0;
      m_prev  = 3'b0;
      clear_tallies();
      for (int i = 0; i < 3; i++) e_duty[i] = 16'd0;
      e_per = 16'd0; e_errp = 1'b0; e_multi = 3'b0; e_ovf = 1'b0;
    end else begin
      if (aligned) begin
        m_per++;
        for (int i = 0; i < 3; i++) begin
          if (s[i]) m_duty[i]++;
          if (s[i] && !m_prev[i]) m_edges[i]++;
        end
        if (h) begin
          e_per = sat16(m_per);
          e_ovf = (m_per > 65535);
          for (int i = 0; i < 3; i++) begin
            e_duty[i]  = sat16(m_duty[i]);
            e_multi[i] = (m_edges[i] >= 2);
            if (m_duty[i] > 65535) e_ovf = 1'b1;
          end
          e_errp  = (e_per != m_top);
          e_valid = 1'b1;
        end
      end
      if (h) begin
        aligned = 1'b1;
        clear_tallies();
        m_top = periodTop;
      end
      m_prev = s;
    end
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    total++;
    if (got !== 70'd0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", got);
    end
    total++;
    if (got !== exp_vec()) begin
      bad++; $display("FAIL reset_model got=%h want=%h", got, exp_vec());
    end
  endtask

  task automatic test_nominal();
    periodTop = 16'd2048;
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    total++;
    if (valid !== 1'b0) begin
      bad++; $display("FAIL nominal_align_valid got=%b want=0", valid);
    end
    for (int i = 0; i < 2048; i++) begin
      step(i < 100, 1'b0, 1'b1, i == 2047, 1'b0);
      total++;
      if (valid !== e_valid) begin
        bad++; $display("FAIL nominal_valid cyc=%0d got=%b want=%b", i, valid, e_valid);
      end
    end
    total++;
    if ({dutyA, dutyB, dutyC, perLen, errPeriod, errMulti, ovf, valid} !==
        {16'd100, 16'd0, 16'd2048, 16'd2048, 1'b0, 3'b000, 1'b0, 1'b1}) begin
      bad++; $display("FAIL nominal_close got=%h A=%0d B=%0d C=%0d per=%0d", got, dutyA, dutyB, dutyC, perLen);
    end
    total++;
    if (got !== exp_vec()) begin
      bad++; $display("FAIL nominal_model got=%h want=%h", got, exp_vec());
    end
  endtask

  task automatic test_mismatch();
    for (int w = 0; w < 2; w++) begin
      int len;
      len = (w == 0) ? 2000 : 2048;
      for (int i = 0; i < len; i++) begin
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), i == len - 1, 1'b0);
        total++;
        if (valid !== e_valid) begin
          bad++; $display("FAIL mismatch_valid w=%0d cyc=%0d got=%b want=%b", w, i, valid, e_valid);
        end
      end
      total++;
      if ({perLen, errPeriod} !== {16'(len), (w == 0)}) begin
        bad++; $display("FAIL mismatch_err w=%0d per=%0d errPeriod=%b want per=%0d err=%b", w, perLen, errPeriod, len, w == 0);
      end
      total++;
      if (got !== exp_vec()) begin
        bad++; $display("FAIL mismatch_model w=%0d got=%h want=%h", w, got, exp_vec());
      end
    end
  endtask

  task automatic test_multi_pulse();
    periodTop = 16'd64;
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 64; i++) begin
        bit b;
        b = (w == 0) ? ((i >= 5 && i < 15) || (i >= 30 && i < 40)) : (i >= 10 && i < 20);
        step(1'b0, b, 1'b0, i == 63, 1'b0);
        total++;
        if (valid !== e_valid) begin
          bad++; $display("FAIL multi_valid w=%0d cyc=%0d got=%b want=%b", w, i, valid, e_valid);
        end
      end
      total++;
      if ({dutyB, errMulti} !== ((w == 0) ? {16'd20, 3'b010} : {16'd10, 3'b000})) begin
        bad++; $display("FAIL multi_close w=%0d dutyB=%0d errMulti=%b", w, dutyB, errMulti);
      end
      total++;
      if (got !== exp_vec()) begin
        bad++; $display("FAIL multi_model w=%0d got=%h want=%h", w, got, exp_vec());
      end
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 70000; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      total++;
      if (valid !== 1'b0) begin
        bad++; $display("FAIL sat_valid cyc=%0d got=%b want=0", i, valid);
      end
    end
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    total++;
    if ({dutyA, perLen, ovf, errPeriod, valid} !== {16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b1}) begin
      bad++; $display("FAIL sat_close dutyA=%h perLen=%h ovf=%b errPeriod=%b valid=%b", dutyA, perLen, ovf, errPeriod, valid);
    end
    total++;
    if (got !== exp_vec()) begin
      bad++; $display("FAIL sat_model got=%h want=%h", got, exp_vec());
    end
  endtask

  task automatic test_reset_mid();
    periodTop = 16'd32;
    for (int i = 0; i < 10; i++) step(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    total++;
    if (got !== 70'd0) begin
      bad++; $display("FAIL rstmid_outputs got=%h want=0", got);
    end
    for (int i = 0; i < 21; i++) begin
      step(1'($urandom_range(0, 1)), 1'b0, 1'b1, i == 20, 1'b0);
      total++;
      if (valid !== 1'b0) begin
        bad++; $display("FAIL rstmid_noalign_valid cyc=%0d got=%b want=0", i, valid);
      end
    end
    for (int i = 0; i < 32; i++) step(1'($urandom_range(0, 1)), 1'b0, 1'b1, i == 31, 1'b0);
    total++;
    if ({valid, perLen, errPeriod, dutyB, dutyC} !== {1'b1, 16'd32, 1'b0, 16'd0, 16'd32}) begin
      bad++; $display("FAIL rstmid_close valid=%b perLen=%0d errPeriod=%b dutyB=%0d dutyC=%0d", valid, perLen, errPeriod, dutyB, dutyC);
    end
    total++;
    if (got !== exp_vec()) begin
      bad++; $display("FAIL rstmid_model got=%h want=%h", got, exp_vec());
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    total++;
    if ({valid, perLen} !== {1'b1, 16'd8}) begin
      bad++; $display("FAIL b2b_first valid=%b perLen=%0d want 1/8", valid, perLen);
    end
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    total++;
    if ({valid, perLen, dutyA, dutyB, dutyC} !== {1'b1, 16'd1, 16'd0, 16'd0, 16'd1}) begin
      bad++; $display("FAIL b2b_second valid=%b perLen=%0d A=%0d B=%0d C=%0d", valid, perLen, dutyA, dutyB, dutyC);
    end
    total++;
    if (got !== exp_vec()) begin
      bad++; $display("FAIL b2b_model got=%h want=%h", got, exp_vec());
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if (valid !== 1'b0) begin
      bad++; $display("FAIL b2b_after_valid got=%b want=0", valid);
    end
  endtask

  task automatic test_random();
    for (int w = 0; w < 8; w++) begin
      int len;
      len = $urandom_range(1, 300);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 7) == 0) periodTop = 16'($urandom_range(1, 300));
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0), i == len - 1, 1'b0);
        total++;
        if (got !== exp_vec()) begin
          bad++; $display("FAIL random w=%0d cyc=%0d got=%h want=%h", w, i, got, exp_vec());
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_duty[i] = 0; m_edges[i] = 0; e_duty[i] = 16'd0;
    end
    @(negedge clk);
    test_reset();
    test_nominal();
    test_mismatch();
    test_multi_pulse();
    test_saturation();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
